// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the PWM output block.
// Optional build macro: PWM_SHADOW_EN (period-aligned duty updates).
package pwm_pkg;

    localparam int NUM_CH    = 16;
    localparam int DUTY_W    = 8;
    localparam int PWM_STEPS = 256;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef logic [NUM_CH-1:0] ch_mask_t;

    localparam duty_t DUTY_FULL = 8'hFF;
    localparam duty_t CNT_LAST  = duty_t'(PWM_STEPS - 1);

    // Full-scale duty is forced high so 0xFF never shows a one-step low pulse.
    function automatic logic pwm_level(input duty_t cnt, input duty_t duty);
        return (duty == DUTY_FULL) | (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Clock prescaler: one-cycle tick every CLK_DIV clk cycles.
// Counter runs 0..CLK_DIV-1; CLK_DIV=1 ticks every cycle.
module pwm_tick_gen #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_MAX);

    // Prescale counter, returns to zero on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM/static output stage fed by the SPI register file.
// Optional build macro: PWM_SHADOW_EN (duty latched at period wrap).
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13,
    parameter int NUM_CH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        en_reg_out_7_0,
    input  logic [7:0]        en_reg_out_15_8,
    input  logic [7:0]        en_reg_pwm_7_0,
    input  logic [7:0]        en_reg_pwm_15_8,
    input  logic [7:0]        pwm_duty_cycle,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    logic     tick;
    logic     wrap;
    logic     pwm_raw;
    duty_t    pwm_cnt;
    duty_t    duty_active;
    ch_mask_t en_out;
    ch_mask_t en_pwm;

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign wrap   = tick & (pwm_cnt == CNT_LAST);

    // Period counter steps once per prescaler tick and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + duty_t'(1);
        end
    end

    // Registered pulse marking the first cycle of each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
        end
    end

`ifdef PWM_SHADOW_EN
    duty_t duty_q;

    // Shadow duty only reloads at the period boundary to avoid runt pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else if (wrap) begin
            duty_q <= pwm_duty_cycle;
        end
    end

    assign duty_active = duty_q;
`else
    assign duty_active = pwm_duty_cycle;
`endif

    assign pwm_raw = pwm_level(pwm_cnt, duty_active);

    // Per-channel mask: off, static high, or shared PWM waveform.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= en_out & (~en_pwm | {NUM_CH{pwm_raw}});
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral (CLK_DIV=13, period 3328 clk).
// Expected values follow PWM_SHADOW_EN when it is defined.
module tb_pwm_peripheral;

    localparam int PER = 13 * 256;

`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out;
    logic        period_start;

    always #5 clk = ~clk;

    pwm_peripheral #(
        .CLK_DIV (13),
        .NUM_CH  (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    typedef struct {
        int          due;
        logic [15:0] exp_out;
        logic [15:0] mask;
        logic        chk_ps;
        logic        exp_ps;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic push(input int due, input logic [15:0] eo, input logic [15:0] m,
                        input logic cps, input logic eps, input string n);
        exp_t e;
        e.due = due; e.exp_out = eo; e.mask = m;
        e.chk_ps = cps; e.exp_ps = eps; e.name = n;
        sb.push_back(e);
    endtask

    // Monitor: pops every expectation due this cycle and compares.
    exp_t cur;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            if (cur.due != cyc) begin
                check({cur.name, "_missed"}, cyc, cur.due);
            end else begin
                if (cur.mask != 16'h0)
                    check({cur.name, "_out"}, {16'h0, out & cur.mask},
                          {16'h0, cur.exp_out & cur.mask});
                if (cur.chk_ps)
                    check({cur.name, "_ps"}, {31'h0, period_start},
                          {31'h0, cur.exp_ps});
            end
        end
    end

    task automatic setin(input logic [15:0] eo, input logic [15:0] ep,
                         input logic [7:0] d);
        {eo_hi, eo_lo} = eo;
        {ep_hi, ep_lo} = ep;
        duty = d;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(input string n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < PER + 700; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({n, "_ps_seen"}, {31'h0, ok}, 32'h1);
    endtask

    // Samples one full period starting right after a period_start sample.
    task automatic measure(output int h0, output int h1, output int mis,
                           output int early, output logic ps_end);
        h0 = 0; h1 = 0; mis = 0; early = 0;
        for (int i = 1; i <= PER; i++) begin
            @(negedge clk);
            if (out[0] === 1'b1) h0++;
            if (out[1] === 1'b1) h1++;
            for (int j = 2; j < 16; j++)
                if (out[j] !== out[j % 2]) mis++;
            if (i < PER && period_start !== 1'b0) early++;
        end
        ps_end = period_start;
    endtask

    logic [7:0] duties[3] = '{8'h00, 8'h80, 8'hFF};
    int         exp_hi[3] = '{0, 1664, 3328};

    initial begin
        int   r, h0, h1, mis, early;
        logic pse;
        string nm;

        // Reset held with every input at 0xFF.
        setin(16'hFFFF, 16'hFFFF, 8'hFF);
        rst_n = 1'b0;
        repeat (2) next_edge();
        for (int i = 1; i <= 4; i++)
            push(cyc + i, 16'h0, 16'hFFFF, 1'b1, 1'b0, "reset_hold");
        repeat (5) next_edge();
        setin(16'h0, 16'h0, 8'h00);
        rst_n = 1'b1;
        r = cyc;
        push(r + PER - 1, 16'h0, 16'hFFFF, 1'b1, 1'b0, "first_ps_pre");
        push(r + PER,     16'h0, 16'hFFFF, 1'b1, 1'b1, "first_ps");
        push(r + PER + 1, 16'h0, 16'hFFFF, 1'b1, 1'b0, "first_ps_post");
        repeat (PER + 1) next_edge();

        // Static modes.
        setin(16'hFFFF, 16'h0000, 8'h00);
        push(cyc + 1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "static_all");
        next_edge();
        setin(16'h00F0, 16'h0000, 8'h00);
        push(cyc + 1, 16'h00F0, 16'hFFFF, 1'b0, 1'b0, "static_f0");
        next_edge();
        setin(16'h0000, 16'hFFFF, 8'hFF);
        push(cyc + 1, 16'h0000, 16'hFFFF, 1'b0, 1'b0, "pwm_no_out");
        next_edge();

        // Duty sweep with every channel in PWM mode.
        for (int k = 0; k < 3; k++) begin
            $sformat(nm, "duty_%02h", duties[k]);
            setin(16'hFFFF, 16'hFFFF, duties[k]);
            wait_ps(nm);
            measure(h0, h1, mis, early, pse);
            check({nm, "_hi0"}, h0, exp_hi[k]);
            check({nm, "_hi1"}, h1, exp_hi[k]);
            check({nm, "_align"}, mis, 0);
            check({nm, "_early_ps"}, early, 0);
            check({nm, "_period"}, {31'h0, pse}, 32'h1);
            next_edge();
        end

        // Mixed: even channels PWM at 25%, odd channels static high.
        setin(16'hFFFF, 16'h5555, 8'h40);
        wait_ps("mixed");
        measure(h0, h1, mis, early, pse);
        check("mixed_even_hi", h0, 832);
        check("mixed_odd_hi", h1, PER);
        check("mixed_align", mis, 0);
        next_edge();

        // Duty change mid-period at pwm_cnt=100.
        setin(16'hFFFF, 16'hFFFF, 8'h20);
        wait_ps("shadow_arm");
        repeat (1300) next_edge();
        push(cyc, 16'h0000, 16'hFFFF, 1'b0, 1'b0, "pre_change");
        duty = 8'hC0;
        push(cyc + 1, SHADOW ? 16'h0000 : 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "chg_1");
        push(cyc + 2, SHADOW ? 16'h0000 : 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "chg_2");
        wait_ps("shadow_next");
        measure(h0, h1, mis, early, pse);
        check("duty_c0_hi", h0, 2496);
        check("duty_c0_period", {31'h0, pse}, 32'h1);

        // Async reset at pwm_cnt=150 while outputs are high.
        repeat (1950) next_edge();
        #1;
        check("pre_reset_out", {16'h0, out}, 32'h0000FFFF);
        rst_n = 1'b0;
        #1;
        check("async_out", {16'h0, out}, 32'h0);
        check("async_ps", {31'h0, period_start}, 32'h0);
        repeat (3) next_edge();
        rst_n = 1'b1;
        r = cyc;
        push(r + 130, SHADOW ? 16'h0000 : 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "rst_duty");
        push(r + PER - 1, 16'h0, 16'h0, 1'b1, 1'b0, "rst_ps_pre");
        push(r + PER,     16'h0, 16'h0, 1'b1, 1'b1, "rst_ps");
        repeat (PER + 2) next_edge();

        for (int i = 0; i < 10 && sb.size() > 0; i++) next_edge();
        if (sb.size() > 0) check("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
